// File: rtl/card_pkg.sv
// Shared types and constants for the card-cancel pick controller.
// The optional undo feature is enabled with CARD_PICK_UNDO_EN.
package card_pkg;

  localparam int NUM_SLOTS      = 8;
  localparam int SLOT_W         = 3;
  localparam int PICK0_LSB      = 0;
  localparam int PICK1_LSB      = SLOT_W;
  localparam int PICK2_LSB      = 2 * SLOT_W;
  localparam int CANCEL_SLOTS_W = 3 * SLOT_W;

  typedef enum logic [2:0] {
    PICK0,
    PICK1,
    PICK2,
    CHECK,
    ISSUE,
    WAIT
  } state_e;

  function automatic logic [NUM_SLOTS-1:0] slotMask(input logic [SLOT_W-1:0] slot);
    slotMask       = '0;
    slotMask[slot] = 1'b1;
  endfunction

  function automatic logic [3:0] countFree(input logic [NUM_SLOTS-1:0] removedMask);
    countFree = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      countFree = countFree + {3'b000, ~removedMask[i]};
    end
  endfunction

endpackage

// File: rtl/card_match_check.sv
// Combinational match rule on three card codes: all equal or all pairwise different.
// Shared with the hint logic, so it carries no state.
module card_match_check #(
  parameter int CODE_W = 3
) (
  input  logic [CODE_W-1:0] code0_i,
  input  logic [CODE_W-1:0] code1_i,
  input  logic [CODE_W-1:0] code2_i,
  output logic              match_o
);

  logic allEqual;
  logic allDiff;

  assign allEqual = (code0_i == code1_i) && (code1_i == code2_i);
  assign allDiff  = (code0_i != code1_i) && (code1_i != code2_i) && (code0_i != code2_i);
  assign match_o  = allEqual || allDiff;

endmodule

// File: rtl/card_pick_ctrl.sv
// Collects three distinct card picks, checks the match rule and issues a held cancel request.
// Defining CARD_PICK_UNDO_EN adds the undo input that steps back one pick.
module card_pick_ctrl
  import card_pkg::*;
#(
  parameter int CODE_W  = 3,
  parameter int SCORE_W = 4
) (
`ifdef CARD_PICK_UNDO_EN
  input  logic                        undo,
`endif
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        pick_valid,
  input  logic [SLOT_W-1:0]           pick_slot,
  input  logic [NUM_SLOTS*CODE_W-1:0] card_codes,
  input  logic                        cancel_done,
  output logic                        pick_ready,
  output logic                        cancel_go,
  output logic [CANCEL_SLOTS_W-1:0]   cancel_slots,
  output logic                        mismatch,
  output logic [NUM_SLOTS-1:0]        removed,
  output logic [SCORE_W-1:0]          score,
  output logic                        game_over
);

  state_e                      state_q, state_d;
  logic [SLOT_W-1:0]           pick0_q, pick0_d;
  logic [SLOT_W-1:0]           pick1_q, pick1_d;
  logic [SLOT_W-1:0]           pick2_q, pick2_d;
  logic [CANCEL_SLOTS_W-1:0]   slots_q, slots_d;
  logic                        cancelGo_q, cancelGo_d;
  logic                        mismatch_q, mismatch_d;
  logic [NUM_SLOTS-1:0]        removed_q, removed_d;
  logic [SCORE_W-1:0]          score_q, score_d;

  logic                        isMatch;
  logic                        slotDistinct;
  logic                        pickAccept;
  logic                        undoReq;

  card_match_check #(.CODE_W(CODE_W)) uMatch (
    .code0_i (card_codes[pick0_q*CODE_W +: CODE_W]),
    .code1_i (card_codes[pick1_q*CODE_W +: CODE_W]),
    .code2_i (card_codes[pick2_q*CODE_W +: CODE_W]),
    .match_o (isMatch)
  );

  assign game_over  = countFree(removed_q) < 4'd3;
  assign pick_ready = ((state_q == PICK0) || (state_q == PICK1) || (state_q == PICK2)) && !game_over;

`ifdef CARD_PICK_UNDO_EN
  assign undoReq = undo && ((state_q == PICK1) || (state_q == PICK2));
`else
  assign undoReq = 1'b0;
`endif

  // A pick must name a live slot that is not already held in this triple.
  always_comb begin
    slotDistinct = 1'b1;
    case (state_q)
      PICK1:   slotDistinct = (pick_slot != pick0_q);
      PICK2:   slotDistinct = (pick_slot != pick0_q) && (pick_slot != pick1_q);
      default: slotDistinct = 1'b1;
    endcase
    pickAccept = pick_valid && pick_ready && !removed_q[pick_slot] && slotDistinct;
  end

  always_comb begin
    state_d    = state_q;
    pick0_d    = pick0_q;
    pick1_d    = pick1_q;
    pick2_d    = pick2_q;
    slots_d    = slots_q;
    cancelGo_d = 1'b0;
    mismatch_d = 1'b0;
    removed_d  = removed_q;
    score_d    = score_q;
    case (state_q)
      PICK0, PICK1, PICK2: begin
        if (undoReq) begin
          if (state_q == PICK1) begin
            pick0_d = '0;
            state_d = PICK0;
          end else begin
            pick1_d = '0;
            state_d = PICK1;
          end
        end else if (pickAccept) begin
          case (state_q)
            PICK0: begin
              pick0_d = pick_slot;
              state_d = PICK1;
            end
            PICK1: begin
              pick1_d = pick_slot;
              state_d = PICK2;
            end
            default: begin
              pick2_d = pick_slot;
              state_d = CHECK;
            end
          endcase
        end
      end
      CHECK: begin
        if (isMatch) begin
          cancelGo_d                         = 1'b1;
          slots_d[PICK0_LSB +: SLOT_W]       = pick0_q;
          slots_d[PICK1_LSB +: SLOT_W]       = pick1_q;
          slots_d[PICK2_LSB +: SLOT_W]       = pick2_q;
          state_d                            = ISSUE;
        end else begin
          mismatch_d = 1'b1;
          pick0_d    = '0;
          pick1_d    = '0;
          pick2_d    = '0;
          state_d    = PICK0;
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        // Completion commits the triple; the slot outputs stay as the last request.
        if (cancel_done) begin
          removed_d = removed_q | slotMask(pick0_q) | slotMask(pick1_q) | slotMask(pick2_q);
          if (score_q != {SCORE_W{1'b1}}) begin
            score_d = score_q + 1'b1;
          end
          pick0_d = '0;
          pick1_d = '0;
          pick2_d = '0;
          state_d = PICK0;
        end
      end
      default: state_d = PICK0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= PICK0;
      pick0_q    <= '0;
      pick1_q    <= '0;
      pick2_q    <= '0;
      slots_q    <= '0;
      cancelGo_q <= 1'b0;
      mismatch_q <= 1'b0;
      removed_q  <= '0;
      score_q    <= '0;
    end else begin
      state_q    <= state_d;
      pick0_q    <= pick0_d;
      pick1_q    <= pick1_d;
      pick2_q    <= pick2_d;
      slots_q    <= slots_d;
      cancelGo_q <= cancelGo_d;
      mismatch_q <= mismatch_d;
      removed_q  <= removed_d;
      score_q    <= score_d;
    end
  end

  assign cancel_go    = cancelGo_q;
  assign cancel_slots = slots_q;
  assign mismatch     = mismatch_q;
  assign removed      = removed_q;
  assign score        = score_q;

endmodule

// File: tb/tb_card_pick_ctrl.sv
// Directed bench for card_pick_ctrl with a result scoreboard; a second instance uses SCORE_W=1.
// The undo scenario runs only when CARD_PICK_UNDO_EN is defined.
module tb_card_pick_ctrl;
  import card_pkg::*;

  typedef struct packed {
    logic       isMatch;
    logic [8:0] slots;
  } result_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        pickValid;
  logic [2:0]  pickSlot;
  logic [23:0] cardCodes;
  logic        cancelDone;
  logic        undo;

  logic        pickReady, cancelGo, mismatch, gameOver;
  logic [8:0]  cancelSlots;
  logic [7:0]  removed;
  logic [3:0]  score;

  logic        satPickReady, satCancelGo, satMismatch, satGameOver;
  logic [8:0]  satCancelSlots;
  logic [7:0]  satRemoved;
  logic [0:0]  satScore;

  result_t     expQ[$];
  int          checks   = 0;
  int          failures = 0;

  card_pick_ctrl #(.CODE_W(3), .SCORE_W(4)) dut (
`ifdef CARD_PICK_UNDO_EN
    .undo         (undo),
`endif
    .clk          (clk),
    .reset        (reset),
    .pick_valid   (pickValid),
    .pick_slot    (pickSlot),
    .card_codes   (cardCodes),
    .cancel_done  (cancelDone),
    .pick_ready   (pickReady),
    .cancel_go    (cancelGo),
    .cancel_slots (cancelSlots),
    .mismatch     (mismatch),
    .removed      (removed),
    .score        (score),
    .game_over    (gameOver)
  );

  card_pick_ctrl #(.CODE_W(3), .SCORE_W(1)) dutSat (
`ifdef CARD_PICK_UNDO_EN
    .undo         (undo),
`endif
    .clk          (clk),
    .reset        (reset),
    .pick_valid   (pickValid),
    .pick_slot    (pickSlot),
    .card_codes   (cardCodes),
    .cancel_done  (cancelDone),
    .pick_ready   (satPickReady),
    .cancel_go    (satCancelGo),
    .cancel_slots (satCancelSlots),
    .mismatch     (satMismatch),
    .removed      (satRemoved),
    .score        (satScore),
    .game_over    (satGameOver)
  );

  initial forever #5 clk = ~clk;

  function automatic logic [2:0] codeOf(input logic [2:0] slot);
    logic [23:0] codes;
    codes  = cardCodes;
    codeOf = codes[slot*3 +: 3];
  endfunction

  function automatic logic modelMatch(input logic [2:0] a, input logic [2:0] b, input logic [2:0] c);
    logic [2:0] ca, cb, cc;
    ca = codeOf(a);
    cb = codeOf(b);
    cc = codeOf(c);
    modelMatch = ((ca == cb) && (cb == cc)) || ((ca != cb) && (cb != cc) && (ca != cc));
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [2:0] slot);
    pickValid = 1'b1;
    pickSlot  = slot;
    tick();
    pickValid = 1'b0;
  endtask

  task automatic pickTriple(input logic [2:0] a, input logic [2:0] b, input logic [2:0] c);
    result_t r;
    r.isMatch = modelMatch(a, b, c);
    r.slots   = {c, b, a};
    expQ.push_back(r);
    applyStimulus(a);
    applyStimulus(b);
    applyStimulus(c);
  endtask

  task automatic doneCycle;
    cancelDone = 1'b1;
    tick();
    cancelDone = 1'b0;
  endtask

  // Waits for the triple outcome, pops the scoreboard and checks kind, slots, latency and pulse width.
  task automatic waitResult(input string tag);
    int      n;
    result_t r;
    n = 0;
    while (!(cancelGo || mismatch) && n < 8) begin
      tick();
      n++;
    end
    if (!(cancelGo || mismatch)) begin
      checkOutput({tag, "_timeout"}, 32'd0, 32'd1);
      return;
    end
    if (expQ.size() == 0) begin
      checkOutput({tag, "_unexpected"}, 32'd0, 32'd1);
      return;
    end
    r = expQ.pop_front();
    checkOutput({tag, "_latency"}, 32'(n), 32'd1);
    checkOutput({tag, "_cancel_go"}, 32'(cancelGo), 32'(r.isMatch));
    checkOutput({tag, "_mismatch"}, 32'(mismatch), 32'(!r.isMatch));
    if (r.isMatch) checkOutput({tag, "_slots"}, 32'(cancelSlots), 32'(r.slots));
    tick();
    checkOutput({tag, "_pulse_end"}, 32'(cancelGo || mismatch), 32'd0);
  endtask

  initial begin
    reset      = 1'b1;
    pickValid  = 1'b0;
    pickSlot   = 3'd0;
    cancelDone = 1'b0;
    undo       = 1'b0;
    cardCodes  = {3'd4, 3'd2, 3'd3, 3'd2, 3'd2, 3'd1, 3'd2, 3'd1};
    repeat (2) tick();

    checkOutput("rst_removed", 32'(removed), 32'd0);
    checkOutput("rst_score", 32'(score), 32'd0);
    checkOutput("rst_cancel_go", 32'(cancelGo), 32'd0);
    checkOutput("rst_mismatch", 32'(mismatch), 32'd0);
    checkOutput("rst_slots", 32'(cancelSlots), 32'd0);
    checkOutput("rst_pick_ready", 32'(pickReady), 32'd1);
    checkOutput("rst_game_over", 32'(gameOver), 32'd0);
    reset = 1'b0;
    tick();

    doneCycle();
    checkOutput("idle_done_removed", 32'(removed), 32'd0);
    checkOutput("idle_done_score", 32'(score), 32'd0);

    pickTriple(3'd1, 3'd4, 3'd6);
    checkOutput("match1_check_state", 32'(dut.state_q), 32'(CHECK));
    waitResult("match1");
    repeat (3) tick();
    checkOutput("wait_slots_held", 32'(cancelSlots), {23'd0, 3'd6, 3'd4, 3'd1});
    checkOutput("wait_pick_ready", 32'(pickReady), 32'd0);
    pickValid  = 1'b1;
    pickSlot   = 3'd0;
    cancelDone = 1'b1;
    tick();
    pickValid  = 1'b0;
    cancelDone = 1'b0;
    checkOutput("match1_removed", 32'(removed), 32'h52);
    checkOutput("match1_score", 32'(score), 32'd1);
    checkOutput("match1_sat_score", 32'(satScore), 32'd1);
    checkOutput("match1_pick_ready", 32'(pickReady), 32'd1);
    checkOutput("wait_pick_dropped", 32'(dut.state_q), 32'(PICK0));

    pickTriple(3'd0, 3'd2, 3'd3);
    waitResult("mismatch");
    checkOutput("mismatch_state", 32'(dut.state_q), 32'(PICK0));
    checkOutput("mismatch_removed", 32'(removed), 32'h52);
    checkOutput("mismatch_score", 32'(score), 32'd1);

    applyStimulus(3'd0);
    applyStimulus(3'd0);
    applyStimulus(3'd4);
    checkOutput("invalid_state", 32'(dut.state_q), 32'(PICK1));
    expQ.push_back('{isMatch: modelMatch(3'd0, 3'd3, 3'd5), slots: {3'd5, 3'd3, 3'd0}});
    applyStimulus(3'd3);
    applyStimulus(3'd5);
    waitResult("match2");
    tick();
    doneCycle();
    checkOutput("match2_removed", 32'(removed), 32'h7B);
    checkOutput("match2_score", 32'(score), 32'd2);
    checkOutput("sat_score", 32'(satScore), 32'd1);
    checkOutput("game_over", 32'(gameOver), 32'd1);
    checkOutput("game_over_ready", 32'(pickReady), 32'd0);
    applyStimulus(3'd2);
    checkOutput("game_over_pick_dropped", 32'(dut.state_q), 32'(PICK0));

    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    pickTriple(3'd1, 3'd4, 3'd6);
    waitResult("match3");
    reset = 1'b1;
    #1;
    checkOutput("wait_rst_removed", 32'(removed), 32'd0);
    checkOutput("wait_rst_score", 32'(score), 32'd0);
    checkOutput("wait_rst_cancel_go", 32'(cancelGo), 32'd0);
    tick();
    reset = 1'b0;
    tick();
    doneCycle();
    checkOutput("late_done_removed", 32'(removed), 32'd0);
    checkOutput("late_done_score", 32'(score), 32'd0);
    checkOutput("late_done_ready", 32'(pickReady), 32'd1);

`ifdef CARD_PICK_UNDO_EN
    applyStimulus(3'd2);
    applyStimulus(3'd5);
    undo      = 1'b1;
    pickValid = 1'b1;
    pickSlot  = 3'd3;
    tick();
    undo      = 1'b0;
    pickValid = 1'b0;
    checkOutput("undo_state", 32'(dut.state_q), 32'(PICK1));
    checkOutput("undo_cleared", 32'(dut.pick1_q), 32'd0);
    expQ.push_back('{isMatch: modelMatch(3'd2, 3'd7, 3'd0), slots: {3'd0, 3'd7, 3'd2}});
    applyStimulus(3'd7);
    applyStimulus(3'd0);
    checkOutput("undo_check_state", 32'(dut.state_q), 32'(CHECK));
    checkOutput("undo_triple", {23'd0, dut.pick2_q, dut.pick1_q, dut.pick0_q}, {23'd0, 3'd0, 3'd7, 3'd2});
    waitResult("undo_result");
`endif

    checkOutput("scoreboard_empty", 32'(expQ.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
